// File: rtl/axi_slave_read_responder.sv
// AXI3 slave read responder: AR acceptance, FIXED/INCR/WRAP R bursts from a backdoor-filled word memory.
// Optional AXI_RD_OUTSTANDING_EN adds a 2-entry in-order AR queue behind the active burst.
module axi_slave_read_responder #(
    parameter int ID_W      = 4,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ID_W-1:0]              ARID,
    input  logic [31:0]                  ARADDR,
    input  logic [3:0]                   ARLEN,
    input  logic [2:0]                   ARSIZE,
    input  logic [1:0]                   ARBURST,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [ID_W-1:0]              RID,
    output logic [31:0]                  RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RLAST,
    output logic                         RVALID,
    input  logic                         RREADY,
    input  logic                         mem_wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_wr_addr,
    input  logic [31:0]                  mem_wr_data,
    input  logic [3:0]                   mem_wr_strb
);
    localparam int AW    = $clog2(MEM_DEPTH);
    localparam int REQ_W = ID_W + 41;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    function automatic logic [31:0] f_next_addr(input logic [31:0] addr, input logic [2:0] size,
                                                input logic [3:0] len, input logic [1:0] burst);
        logic [31:0] inc, span, res;
        inc  = 32'd1 << size;
        span = ({28'd0, len} + 32'd1) << size;
        case (burst)
            2'b00:   res = addr;
            2'b10:   res = (addr & ~(span - 32'd1)) | ((addr + inc) & (span - 32'd1));
            default: res = addr + inc;
        endcase
        return res;
    endfunction

    function automatic logic f_slverr(input logic [31:0] addr, input logic [2:0] size,
                                      input logic [3:0] len, input logic [1:0] burst);
        logic bad_wrap;
        bad_wrap = !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15) ||
                   ((addr & ((32'd1 << size) - 32'd1)) != 32'd0);
        return (burst == 2'b11) || (size > 3'd2) || ((burst == 2'b10) && bad_wrap);
    endfunction

    logic [31:0]     r_mem [MEM_DEPTH];
    state_t          r_state, w_state_nxt;
    logic            r_arready, r_rvalid, r_rlast;
    logic [ID_W-1:0] r_rid;
    logic [31:0]     r_rdata, r_addr;
    logic [1:0]      r_rresp, r_burst;
    logic [3:0]      r_len, r_cnt;
    logic [2:0]      r_size;
    logic            r_err;

    logic             w_ar_hs, w_r_hs, w_last_hs, w_start, w_load, w_arready_nxt;
    logic [REQ_W-1:0] w_ar_req, w_src_req;
    logic [ID_W-1:0]  w_src_id;
    logic [31:0]      w_src_addr, w_beat_addr, w_mem_rd, w_beat_data;
    logic [3:0]       w_src_len, w_beat_len, w_beat_cnt;
    logic [2:0]       w_src_size;
    logic [1:0]       w_src_burst, w_beat_resp;
    logic             w_beat_err, w_decerr, w_beat_last;

    assign w_ar_hs   = ARVALID && r_arready;
    assign w_r_hs    = r_rvalid && RREADY;
    assign w_last_hs = w_r_hs && r_rlast;
    assign w_ar_req  = {ARID, ARADDR, ARLEN, ARSIZE, ARBURST};

`ifdef AXI_RD_OUTSTANDING_EN
    logic [REQ_W-1:0] r_q [2];
    logic [1:0]       r_qcnt, w_qcnt_nxt;
    logic             w_push, w_pop, w_push_idx;

    // A queued request takes precedence over a fresh AR so ordering is preserved.
    assign w_start       = ((r_state == S_IDLE) || w_last_hs) && ((r_qcnt != 2'd0) || w_ar_hs);
    assign w_pop         = w_start && (r_qcnt != 2'd0);
    assign w_push        = w_ar_hs && !(w_start && (r_qcnt == 2'd0));
    assign w_qcnt_nxt    = r_qcnt + {1'b0, w_push} - {1'b0, w_pop};
    assign w_push_idx    = ((r_qcnt - {1'b0, w_pop}) == 2'd1);
    assign w_src_req     = (r_qcnt != 2'd0) ? r_q[0] : w_ar_req;
    assign w_arready_nxt = (w_qcnt_nxt != 2'd2);

    always_ff @(posedge clock) begin
        if (!reset) r_qcnt <= 2'd0;
        else        r_qcnt <= w_qcnt_nxt;
    end

    always_ff @(posedge clock) begin
        if (w_pop)  r_q[0] <= r_q[1];
        if (w_push) r_q[w_push_idx] <= w_ar_req;
    end
`else
    assign w_start       = w_ar_hs;
    assign w_src_req     = w_ar_req;
    assign w_arready_nxt = (w_state_nxt == S_IDLE);
`endif

    assign {w_src_id, w_src_addr, w_src_len, w_src_size, w_src_burst} = w_src_req;

    assign w_load      = w_start || (w_r_hs && !r_rlast);
    assign w_beat_addr = w_start ? w_src_addr : f_next_addr(r_addr, r_size, r_len, r_burst);
    assign w_beat_err  = w_start ? f_slverr(w_src_addr, w_src_size, w_src_len, w_src_burst) : r_err;
    assign w_beat_len  = w_start ? w_src_len : r_len;
    assign w_beat_cnt  = w_start ? 4'd0 : r_cnt + 4'd1;
    assign w_beat_last = (w_beat_cnt == w_beat_len);
    assign w_decerr    = ({2'b00, w_beat_addr[31:2]} >= 32'(MEM_DEPTH));
    assign w_mem_rd    = r_mem[w_beat_addr[AW+1:2]];
    assign w_beat_data = (w_beat_err || w_decerr) ? 32'd0 : w_mem_rd;
    assign w_beat_resp = w_beat_err ? 2'b10 : (w_decerr ? 2'b11 : 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_BURST;
            S_BURST: if (w_last_hs && !w_start) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_rresp   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_arready <= w_arready_nxt;
            if (w_load) begin
                r_rvalid <= 1'b1;
                r_rlast  <= w_beat_last;
                r_rdata  <= w_beat_data;
                r_rresp  <= w_beat_resp;
                if (w_start) r_rid <= w_src_id;
            end else if (w_last_hs) begin
                r_rvalid <= 1'b0;
                r_rlast  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_load) begin
            r_addr <= w_beat_addr;
            r_cnt  <= w_beat_cnt;
        end
        if (w_start) begin
            r_len   <= w_src_len;
            r_size  <= w_src_size;
            r_burst <= w_src_burst;
            r_err   <= w_beat_err;
        end
    end

    // Write commits at the edge, so a same-cycle beat read still sees the old word.
    always_ff @(posedge clock) begin
        if (mem_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wr_strb[b]) r_mem[mem_wr_addr][8*b +: 8] <= mem_wr_data[8*b +: 8];
            end
        end
    end

    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RLAST   = r_rlast;
    assign RID     = r_rid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
endmodule

// File: tb/tb_axi_slave_read_responder.sv
// Directed bench for axi_slave_read_responder (default single-outstanding build).
module tb_axi_slave_read_responder;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_strb;

    int n_cmp  = 0;
    int n_fail = 0;

    axi_slave_read_responder #(.ID_W(4), .MEM_DEPTH(256)) dut (
        .clock(clock), .reset(reset),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_strb(mem_wr_strb)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_wr_en = 1'b1; mem_wr_addr = a; mem_wr_data = d; mem_wr_strb = s;
        step();
        mem_wr_en = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int k = 0;
        while (!ARREADY && k < 20) begin step(); k++; end
        chk("arready_wait", 32'(ARREADY), 32'd1);
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        step();
        ARVALID = 1'b0;
        chk("r_latency", 32'(RVALID), 32'd1);
        chk("rid", 32'(RID), 32'(id));
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic [1:0] r, input logic l);
        int k = 0;
        RREADY = 1'b1;
        while (!RVALID && k < 20) begin step(); k++; end
        chk({tag, "_valid"}, 32'(RVALID), 32'd1);
        chk({tag, "_data"}, RDATA, d);
        chk({tag, "_resp"}, 32'(RRESP), 32'(r));
        chk({tag, "_last"}, 32'(RLAST), 32'(l));
        step();
    endtask

    initial begin
        reset = 1'b0; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
        RREADY = 1'b0; mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0; mem_wr_strb = '0;
        step();
        for (int i = 0; i < 8; i++) wr(8'(i), 32'hA0 + 32'(i), 4'hF);
        wr(8'd254, 32'h0000B0FE, 4'hF);
        wr(8'd255, 32'h0000B0FF, 4'hF);
        wr(8'd10, 32'h11223344, 4'hF);
        wr(8'd10, 32'hFFFFFFFF, 4'b0010);
        chk("rst_arready", 32'(ARREADY), 32'd0);
        chk("rst_rvalid", 32'(RVALID), 32'd0);
        chk("rst_rlast", 32'(RLAST), 32'd0);
        chk("rst_rid", 32'(RID), 32'd0);
        chk("rst_rdata", RDATA, 32'd0);
        chk("rst_rresp", 32'(RRESP), 32'd0);
        reset = 1'b1;
        step();
        chk("post_rst_arready", 32'(ARREADY), 32'd1);

        send_ar(4'd3, 32'h0, 4'd3, 3'd2, 2'b01);
        chk("incr_arready_busy", 32'(ARREADY), 32'd0);
        beat("incr0", 32'hA0, 2'b00, 1'b0);
        beat("incr1", 32'hA1, 2'b00, 1'b0);
        beat("incr2", 32'hA2, 2'b00, 1'b0);
        chk("incr_rid", 32'(RID), 32'd3);
        beat("incr3", 32'hA3, 2'b00, 1'b1);
        chk("incr_end_rvalid", 32'(RVALID), 32'd0);
        chk("incr_end_arready", 32'(ARREADY), 32'd1);

        send_ar(4'd1, 32'h8, 4'd3, 3'd2, 2'b10);
        beat("wrap0", 32'hA2, 2'b00, 1'b0);
        beat("wrap1", 32'hA3, 2'b00, 1'b0);
        beat("wrap2", 32'hA0, 2'b00, 1'b0);
        beat("wrap3", 32'hA1, 2'b00, 1'b1);

        send_ar(4'd2, 32'h3F8, 4'd3, 3'd2, 2'b01);
        beat("dec0", 32'hB0FE, 2'b00, 1'b0);
        beat("dec1", 32'hB0FF, 2'b00, 1'b0);
        beat("dec2", 32'h0, 2'b11, 1'b0);
        beat("dec3", 32'h0, 2'b11, 1'b1);

        send_ar(4'd4, 32'h0, 4'd1, 3'd2, 2'b11);
        beat("rsvd0", 32'h0, 2'b10, 1'b0);
        beat("rsvd1", 32'h0, 2'b10, 1'b1);
        send_ar(4'd4, 32'h0, 4'd0, 3'd3, 2'b01);
        beat("size3", 32'h0, 2'b10, 1'b1);

        send_ar(4'd7, 32'h28, 4'd1, 3'd2, 2'b00);
        beat("fixed0", 32'h1122FF44, 2'b00, 1'b0);
        beat("fixed1", 32'h1122FF44, 2'b00, 1'b1);

        send_ar(4'd8, 32'h10, 4'd3, 3'd2, 2'b01);
        beat("stall0", 32'hA4, 2'b00, 1'b0);
        RREADY = 1'b0;
        chk("stall_a_data", RDATA, 32'hA5);
        step();
        chk("stall_b_valid", 32'(RVALID), 32'd1);
        chk("stall_b_data", RDATA, 32'hA5);
        chk("stall_b_last", 32'(RLAST), 32'd0);
        step();
        chk("stall_c_data", RDATA, 32'hA5);
        beat("stall1", 32'hA5, 2'b00, 1'b0);
        beat("stall2", 32'hA6, 2'b00, 1'b0);
        beat("stall3", 32'hA7, 2'b00, 1'b1);
        chk("stall_end_rvalid", 32'(RVALID), 32'd0);

        send_ar(4'd6, 32'h0, 4'd7, 3'd2, 2'b01);
        beat("abort0", 32'hA0, 2'b00, 1'b0);
        chk("abort_beat2_data", RDATA, 32'hA1);
        reset = 1'b0;
        step();
        chk("abort_rvalid", 32'(RVALID), 32'd0);
        chk("abort_arready", 32'(ARREADY), 32'd0);
        chk("abort_rlast", 32'(RLAST), 32'd0);
        chk("abort_rdata", RDATA, 32'd0);
        reset = 1'b1;
        RREADY = 1'b0;
        step();
        chk("abort_rel_arready", 32'(ARREADY), 32'd1);
        chk("abort_rel_rvalid", 32'(RVALID), 32'd0);
        send_ar(4'd5, 32'h4, 4'd0, 3'd2, 2'b01);
        beat("after_rst", 32'hA1, 2'b00, 1'b1);

        chk("coll_arready", 32'(ARREADY), 32'd1);
        ARID = 4'd2; ARADDR = 32'h0; ARLEN = 4'd1; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
        mem_wr_en = 1'b1; mem_wr_addr = 8'd0; mem_wr_data = 32'hDEAD0000; mem_wr_strb = 4'hF;
        step();
        ARVALID = 1'b0; mem_wr_en = 1'b0;
        beat("coll0", 32'hA0, 2'b00, 1'b0);
        beat("coll1", 32'hA1, 2'b00, 1'b1);
        send_ar(4'd9, 32'h0, 4'd0, 3'd2, 2'b01);
        beat("newword", 32'hDEAD0000, 2'b00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
